uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte sources (command responder, status reporter, debug echo, …). It grants one requester at a time and forwards bytes in bursts of up to `MAX_BURST` or until packet end. It launches each byte with a one-cycle start pulse and waits for the transmitter's done pulse before sending the next. It sits between the system's byte producers and the UART TX serializer, which shares the baud tick generator with the UART receiver.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / UART-TX handshake bundle shared by the arbiter and its environment.
// master is the arbiter side; slave is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           Req;
  logic [NUM_REQ*DATA_BITS-1:0] ReqData;
  logic [NUM_REQ-1:0]           ReqLast;
  logic [NUM_REQ-1:0]           Grant;
  logic [NUM_REQ-1:0]           Ack;
  logic                         TxStart;
  logic [DATA_BITS-1:0]         TxData;
  logic                         TxDone;
  logic                         Busy;

  modport master (
    input  Req, ReqData, ReqLast, TxDone,
    output Grant, Ack, TxStart, TxData, Busy
  );

  modport slave (
    output Req, ReqData, ReqLast, TxDone,
    input  Grant, Ack, TxStart, TxData, Busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// forwarding bursts of up to MAX_BURST bytes or until packet end per grant.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               Clock,
  input logic               ResetN,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2
  } stateT;

  stateT              state;
  logic [PTR_W-1:0]   pointer;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   burstCount;
  logic               lastFlag;

  logic               pickValid;
  logic [PTR_W-1:0]   pickIdx;
  logic [NUM_REQ-1:0] pickOneHot;
  logic [PTR_W-1:0]   nextPtr;
  logic               ownerReq;
  logic               ownerLast;
  logic [DATA_BITS-1:0] ownerData;
  logic               releaseNow;

  // First requester at or after pointer in circular order.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand      = '0;
    pickValid = 1'b0;
    pickIdx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(pointer) + i) % NUM_REQ);
      if (!pickValid && bus.Req[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  assign pickOneHot = NUM_REQ'(1) << pickIdx;
  assign nextPtr    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

  // Current owner's request, last flag and byte.
  always_comb begin
    ownerReq  = 1'b0;
    ownerLast = 1'b0;
    ownerData = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == PTR_W'(i)) begin
        ownerReq  = bus.Req[i];
        ownerLast = bus.ReqLast[i];
        ownerData = bus.ReqData[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign releaseNow = lastFlag || (burstCount == CNT_W'(MAX_BURST)) || !ownerReq;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state       <= StIdle;
      pointer     <= '0;
      owner       <= '0;
      burstCount  <= '0;
      lastFlag    <= 1'b0;
      bus.Grant   <= '0;
      bus.Ack     <= '0;
      bus.TxStart <= 1'b0;
      bus.TxData  <= '0;
      bus.Busy    <= 1'b0;
    end else begin
      bus.TxStart <= 1'b0;
      bus.Ack     <= '0;
      unique case (state)
        StIdle: begin
          if (pickValid) begin
            owner      <= pickIdx;
            bus.Grant  <= pickOneHot;
            bus.Busy   <= 1'b1;
            burstCount <= '0;
            state      <= StSend;
          end
        end
        StSend: begin
          if (ownerReq) begin
            bus.TxData  <= ownerData;
            bus.TxStart <= 1'b1;
            bus.Ack     <= bus.Grant;
            lastFlag    <= ownerLast;
            burstCount  <= burstCount + CNT_W'(1);
            state       <= StWait;
          end else begin
            // Requester withdrew before its byte was taken.
            pointer   <= nextPtr;
            bus.Grant <= '0;
            bus.Busy  <= 1'b0;
            state     <= StIdle;
          end
        end
        StWait: begin
          if (bus.TxDone) begin
            if (releaseNow) begin
              pointer   <= nextPtr;
              bus.Grant <= '0;
              bus.Busy  <= 1'b0;
              state     <= StIdle;
            end else begin
              state <= StSend;
            end
          end
        end
        default: begin
          bus.Grant <= '0;
          bus.Busy  <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed timing cases plus randomized
// queue-driven rounds scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DB = 8;
  localparam int MB = 4;

  logic Clock = 1'b0;
  logic ResetN;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .MAX_BURST(MB)) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int numCompared   = 0;
  int numMismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Environment state
  bit         autoMode   = 1'b0;
  int         doneCnt    = 0;
  int         startCount = 0;
  logic       prevStart  = 1'b0;
  logic [7:0] dataQ[NR][$];
  bit         lastQ[NR][$];
  logic [7:0] mData[NR][$];
  bit         mLast[NR][$];
  int         expOwner[$];
  logic [7:0] expData[$];
  int         modelPtr = 0;

  function automatic int oneHotIdx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic driveReqs();
    for (int i = 0; i < NR; i++) begin
      if (dataQ[i].size() > 0) begin
        bus.Req[i]              = 1'b1;
        bus.ReqData[i*DB +: DB] = dataQ[i][0];
        bus.ReqLast[i]          = lastQ[i][0];
      end else begin
        bus.Req[i]              = 1'b0;
        bus.ReqData[i*DB +: DB] = '0;
        bus.ReqLast[i]          = 1'b0;
      end
    end
  endtask

  task automatic pushByte(input int r, input logic [7:0] d, input bit l);
    dataQ[r].push_back(d);
    lastQ[r].push_back(l);
  endtask

  // Reference: whole-packet round-robin over preloaded queues.
  task automatic buildExpected();
    int  g;
    int  n;
    bit  last;
    for (int i = 0; i < NR; i++) begin
      mData[i] = dataQ[i];
      mLast[i] = lastQ[i];
    end
    while (1) begin
      g = -1;
      for (int k = 0; k < NR; k++)
        if (g < 0 && mData[(modelPtr + k) % NR].size() > 0) g = (modelPtr + k) % NR;
      if (g < 0) break;
      n = 0;
      do begin
        expOwner.push_back(g);
        expData.push_back(mData[g].pop_front());
        last = mLast[g].pop_front();
        n++;
      end while (!last && n < MB && mData[g].size() > 0);
      modelPtr = (g + 1) % NR;
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    if (bus.TxStart || bus.Ack != '0)
      checkVal("ackWithStart", 32'(bus.Ack), bus.TxStart ? 32'(bus.Grant) : 32'd0);
    if (bus.TxStart) begin
      startCount++;
      checkVal("startOneCycle", 32'(prevStart), 32'd0);
    end
    prevStart = bus.TxStart;
    if (autoMode) begin
      bus.TxDone = 1'b0;
      if (bus.TxStart) begin
        if (expOwner.size() == 0) checkVal("unexpectedStart", 32'(bus.TxStart), 32'd0);
        else begin
          checkVal("owner", 32'(oneHotIdx(bus.Grant)), 32'(expOwner.pop_front()));
          checkVal("txData", 32'(bus.TxData), 32'(expData.pop_front()));
        end
        doneCnt = $urandom_range(1, 6);
      end else if (doneCnt > 0) begin
        doneCnt--;
        if (doneCnt == 0) bus.TxDone = 1'b1;
      end
      for (int i = 0; i < NR; i++)
        if (bus.Ack[i] && dataQ[i].size() > 0) begin
          void'(dataQ[i].pop_front());
          void'(lastQ[i].pop_front());
        end
      driveReqs();
    end
  endtask

  task automatic runRound(input string name);
    int budget;
    int left;
    budget = 0;
    buildExpected();
    driveReqs();
    autoMode = 1'b1;
    while ((expOwner.size() > 0 || bus.Busy || doneCnt > 0) && budget < 3000) begin
      tick();
      budget++;
    end
    checkVal({name, "_inTime"}, 32'(budget < 3000), 32'd1);
    autoMode = 1'b0;
    repeat (3) tick();
    left = 0;
    for (int i = 0; i < NR; i++) left += dataQ[i].size();
    checkVal({name, "_idle"}, 32'(bus.Busy), 32'd0);
    checkVal({name, "_expLeft"}, 32'(expOwner.size()), 32'd0);
    checkVal({name, "_dataLeft"}, 32'(left), 32'd0);
    expOwner.delete();
    expData.delete();
    for (int i = 0; i < NR; i++) begin
      dataQ[i].delete();
      lastQ[i].delete();
    end
    driveReqs();
  endtask

  initial begin
    int s0;
    ResetN      = 1'b0;
    bus.Req     = '0;
    bus.ReqData = '0;
    bus.ReqLast = '0;
    bus.TxDone  = 1'b0;
    tick();
    tick();
    checkVal("rstGrant", 32'(bus.Grant), 32'd0);
    checkVal("rstAck", 32'(bus.Ack), 32'd0);
    checkVal("rstTxStart", 32'(bus.TxStart), 32'd0);
    checkVal("rstTxData", 32'(bus.TxData), 32'd0);
    checkVal("rstBusy", 32'(bus.Busy), 32'd0);
    ResetN = 1'b1;
    tick();

    // Single request with late done
    s0 = startCount;
    bus.Req = 4'b0001; bus.ReqData[7:0] = 8'hA5; bus.ReqLast = 4'b0001;
    tick();
    checkVal("singleGrant", 32'(bus.Grant), 32'h1);
    checkVal("singleBusy", 32'(bus.Busy), 32'd1);
    checkVal("singleNoEarlyStart", 32'(bus.TxStart), 32'd0);
    tick();
    checkVal("singleStart", 32'(bus.TxStart), 32'd1);
    checkVal("singleAck", 32'(bus.Ack), 32'h1);
    checkVal("singleData", 32'(bus.TxData), 32'hA5);
    bus.Req = '0;
    repeat (9) tick();
    checkVal("singleHoldGrant", 32'(bus.Grant), 32'h1);
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    checkVal("singleRelGrant", 32'(bus.Grant), 32'd0);
    checkVal("singleRelBusy", 32'(bus.Busy), 32'd0);
    repeat (3) tick();
    checkVal("singleOneStart", 32'(startCount - s0), 32'd1);

    // Reset in WAIT; the late done must be ignored, pointer back to 0
    bus.Req = 4'b1000; bus.ReqData[31:24] = 8'h77; bus.ReqLast = '0;
    tick();
    checkVal("rstMidGrant3", 32'(bus.Grant), 32'h8);
    tick();
    checkVal("rstMidStart", 32'(bus.TxStart), 32'd1);
    ResetN = 1'b0;
    tick();
    checkVal("rstMidGrant", 32'(bus.Grant), 32'd0);
    checkVal("rstMidAck", 32'(bus.Ack), 32'd0);
    checkVal("rstMidTxStart", 32'(bus.TxStart), 32'd0);
    checkVal("rstMidTxData", 32'(bus.TxData), 32'd0);
    checkVal("rstMidBusy", 32'(bus.Busy), 32'd0);
    ResetN = 1'b1;
    bus.Req = '0;
    s0 = startCount;
    tick();
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    tick();
    checkVal("lateDoneGrant", 32'(bus.Grant), 32'd0);
    checkVal("lateDoneNoStart", 32'(startCount - s0), 32'd0);
    bus.Req = 4'b1001; bus.ReqData[7:0] = 8'h5A;
    tick();
    checkVal("rstPtrZero", 32'(bus.Grant), 32'h1);
    bus.Req = '0;
    tick();
    checkVal("wd0Grant", 32'(bus.Grant), 32'd0);

    // Spurious done while idle
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    tick();
    checkVal("spurGrant", 32'(bus.Grant), 32'd0);
    checkVal("spurBusy", 32'(bus.Busy), 32'd0);
    checkVal("spurStart", 32'(bus.TxStart), 32'd0);

    // Withdrawal in SEND by requester 2, then pointer must be 3
    s0 = startCount;
    bus.Req = 4'b0100; bus.ReqData[23:16] = 8'h42;
    tick();
    checkVal("wdGrant2", 32'(bus.Grant), 32'h4);
    bus.Req = '0;
    tick();
    checkVal("wdNoStart", 32'(bus.TxStart), 32'd0);
    checkVal("wdGrantClr", 32'(bus.Grant), 32'd0);
    checkVal("wdBusyClr", 32'(bus.Busy), 32'd0);
    bus.Req = 4'b1001;
    tick();
    checkVal("wdPtr3", 32'(bus.Grant), 32'h8);
    bus.Req = '0;
    tick();
    checkVal("wdNoStarts", 32'(startCount - s0), 32'd0);
    modelPtr = 0;

    // Fairness: every byte is a packet end
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 2; k++) pushByte(i, 8'(16 * i + k), 1'b1);
    runRound("fair");

    // Burst limit: requester 1 streams six bytes, requester 2 waits
    for (int k = 0; k < 6; k++) pushByte(1, 8'(8'h10 + k), 1'b0);
    pushByte(2, 8'h20, 1'b1);
    runRound("burst");

    // Packet end below burst limit
    pushByte(0, 8'h01, 1'b0);
    pushByte(0, 8'h02, 1'b1);
    pushByte(3, 8'h30, 1'b1);
    pushByte(3, 8'h31, 1'b1);
    runRound("packet");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 3) != 0)
          for (int k = 0; k < int'($urandom_range(1, 7)); k++)
            pushByte(i, 8'($urandom), $urandom_range(0, 2) == 0);
      runRound($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end
endmodule
